warp_fetch_scheduler: RTL and testbench
=======================================

// Module: warp_fetch_scheduler
// PURPOSE
// Per-compute-unit fetch scheduler between the per-warp reconvergence stack and the fetcher.
// Each cycle it picks one ready warp round-robin and marks it selected towards the stack.
// It holds that warp's PC and active mask in a 1-entry output register with a valid/ready handshake to the fetcher.
// It also sequences kernel start (set-ready pulse to the stack) and detects kernel completion.
// PARAMETERS
// PcWidth    32  width of program counter
// NumWarps   32  warps per compute unit (>=1)
// WarpWidth  32  threads per warp (active-mask width)
// WidWidth   NumWarps>1 ? $clog2(NumWarps) : 1   derived, do not override
// PORTS
// clk_i             in   1            clock, rising edge
// rst_i             in   1            asynchronous reset, active-high
// start_i           in   1            kernel start request (pulse)
// set_ready_o       out  1            one-cycle pulse to stack: activate all warps
// warp_active_i     in   NumWarps     per-warp active flag from stack
// warp_stopped_i    in   NumWarps     per-warp stopped flag from stack
// warp_ready_i      in   NumWarps     per-warp ready from stack (already qualified by active and mask!=0)
// warp_pc_i         in   NumWarps*PcWidth     per-warp PC
// warp_act_mask_i   in   NumWarps*WarpWidth   per-warp active mask
// warp_selected_o   out  NumWarps     one-hot (or zero) grant to stack, combinational
// fetch_valid_o     out  1            output register holds a valid request
// fetch_ready_i     in   1            fetcher accepts request
// fetch_wid_o       out  WidWidth     warp id of request
// fetch_pc_o        out  PcWidth      PC of request
// fetch_act_mask_o  out  WarpWidth    active mask of request
// busy_o            out  1            state is INIT, RUN or DRAIN
// done_o            out  1            state is DONE
// issued_cnt_o      out  32           number of requests accepted by fetcher since last start
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; rr pointer=0; issued_cnt=0; output register invalid.
// - FSM:
//   IDLE/DONE --start_i--> INIT.
//   INIT: set_ready_o=1 for exactly this cycle --> RUN unconditionally.
//   RUN: issue. When warp_stopped_i==all-ones --> DRAIN.
//   DRAIN: no new grants; when !fetch_valid_o, or the held request is accepted this cycle --> DONE.
// - start_i is ignored outside IDLE/DONE. Entering INIT clears issued_cnt and sets the rr pointer to 0.
// - Grant: load_en = (state==RUN) && (!fetch_valid_o || fetch_ready_i).
//   If load_en and |warp_ready_i, grant the first ready warp at or after the rr pointer (modulo NumWarps).
//   warp_selected_o is one-hot for that warp in the same cycle; otherwise it is 0.
// - On grant: next cycle fetch_valid_o=1 and wid/pc/mask = the granted warp's values sampled this cycle.
//   rr pointer = (granted wid + 1) mod NumWarps.
// - Latency: ready warp -> warp_selected_o 0 cycles; -> fetch_valid_o 1 cycle.
//   Back-to-back issue (1 per cycle) is sustained while fetch_ready_i=1.
// - Handshake: while fetch_valid_o && !fetch_ready_i, wid/pc/mask are held stable and no grant is made.
//   On accept without a new grant, fetch_valid_o drops next cycle.
// - A warp is never granted while its request sits in the output register.
//   The stack clears its ready the cycle after grant, so no extra masking is needed.
// - issued_cnt_o increments on fetch_valid_o && fetch_ready_i and wraps 2^32-1 -> 0.
// - NumWarps==1: the rr pointer stays 0. A wrap-around search with a single candidate is legal.
// - Reset mid-operation: immediate return to reset values. An in-flight request is dropped without handshake.
// - Assertions: warp_selected_o is onehot0. Any grant implies warp_ready_i of that warp.
//   fetch_* outputs are stable while valid && !ready.
// TESTING
// - Reset then start_i pulse -> set_ready_o high exactly 1 cycle after start and busy_o=1.
//   A second start_i during RUN has no effect.
// - NumWarps=4, all ready, fetch_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
//   Stack model drops ready for 2 cycles after grant.
// - Ready only warps 1 and 3, last grant=3 -> next grant warp 1. fetch_wid_o=1 one cycle later with matching pc/mask.
// - fetch_ready_i=0 for 5 cycles with request wid=2, pc=0x40 -> outputs held, warp_selected_o=0 throughout.
//   Released -> issued_cnt_o +1.
// - All warps stopped while a request is held (fetch_ready_i=0) -> state DRAIN.
//   Request accepted -> done_o=1 next cycle, then start_i -> INIT.
// - Assert rst_i mid-RUN with fetch_valid_o=1 -> all outputs 0 asynchronously, issued_cnt_o=0.

Source files
------------

// File: rtl/warp_fetch_scheduler.sv
// Purpose: round-robin pick of one ready warp per cycle, captured with its PC/mask into a 1-entry fetch register.
// Latency: warp_ready_i -> warp_selected_o 0 cycles (comb), -> fetch_valid_o 1 cycle; 1 issue/cycle sustained.
// Backpressure: while fetch_valid_o && !fetch_ready_i the register holds and no grant is made.
module warp_fetch_scheduler #(
  parameter int PcWidth   = 32,
  parameter int NumWarps  = 32,
  parameter int WarpWidth = 32,
  localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  output logic                          set_ready_o,
  input  logic [NumWarps-1:0]           warp_active_i,
  input  logic [NumWarps-1:0]           warp_stopped_i,
  input  logic [NumWarps-1:0]           warp_ready_i,
  input  logic [NumWarps*PcWidth-1:0]   warp_pc_i,
  input  logic [NumWarps*WarpWidth-1:0] warp_act_mask_i,
  output logic [NumWarps-1:0]           warp_selected_o,
  output logic                          fetch_valid_o,
  input  logic                          fetch_ready_i,
  output logic [WidWidth-1:0]           fetch_wid_o,
  output logic [PcWidth-1:0]            fetch_pc_o,
  output logic [WarpWidth-1:0]          fetch_act_mask_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [31:0]                   issued_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [WidWidth-1:0]  rr_q, rr_d;
  logic                 vld_q, vld_d;
  logic [WidWidth-1:0]  wid_q, wid_d;
  logic [PcWidth-1:0]   pc_q, pc_d;
  logic [WarpWidth-1:0] mask_q, mask_d;
  logic [31:0]          cnt_q, cnt_d;

  logic                 load_en;
  logic                 enter_init;
  logic                 grant_vld;
  logic [WidWidth-1:0]  grant_wid;

  assign load_en    = (state_q == S_RUN) && (!vld_q || fetch_ready_i);
  assign enter_init = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: kernel start, run, drain of the held request, completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_INIT;
      S_INIT:         state_d = S_RUN;
      S_RUN:          if (&warp_stopped_i) state_d = S_DRAIN;
      S_DRAIN:        if (!vld_q || fetch_ready_i) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only
  always_comb begin
    set_ready_o = (state_q == S_INIT);
    busy_o      = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o      = (state_q == S_DONE);
  end

  // Round-robin search: descending scan so the smallest offset from rr_q wins
  always_comb begin
    grant_vld = 1'b0;
    grant_wid = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      if (load_en && warp_ready_i[(int'(rr_q) + i) % NumWarps]) begin
        grant_vld = 1'b1;
        grant_wid = WidWidth'((int'(rr_q) + i) % NumWarps);
      end
    end
  end

  // One-hot grant towards the stack
  always_comb begin
    warp_selected_o = '0;
    for (int w = 0; w < NumWarps; w++) begin
      warp_selected_o[w] = grant_vld && (grant_wid == WidWidth'(w));
    end
  end

  // Output register, rr pointer and issue counter next-state
  always_comb begin
    vld_d  = vld_q;
    wid_d  = wid_q;
    pc_d   = pc_q;
    mask_d = mask_q;
    rr_d   = rr_q;
    cnt_d  = cnt_q;
    if (vld_q && fetch_ready_i) begin
      cnt_d = cnt_q + 32'd1;
      vld_d = 1'b0;
    end
    if (grant_vld) begin
      vld_d  = 1'b1;
      wid_d  = grant_wid;
      pc_d   = warp_pc_i[int'(grant_wid)*PcWidth +: PcWidth];
      mask_d = warp_act_mask_i[int'(grant_wid)*WarpWidth +: WarpWidth];
      rr_d   = (grant_wid == WidWidth'(NumWarps - 1)) ? '0 : grant_wid + 1'b1;
    end
    if (enter_init) begin
      cnt_d = '0;
      rr_d  = '0;
    end
  end

  // Datapath registers; reset drops any in-flight request without handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      wid_q  <= '0;
      pc_q   <= '0;
      mask_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      wid_q  <= wid_d;
      pc_q   <= pc_d;
      mask_q <= mask_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fetch_valid_o    = vld_q;
  assign fetch_wid_o      = wid_q;
  assign fetch_pc_o       = pc_q;
  assign fetch_act_mask_o = mask_q;
  assign issued_cnt_o     = cnt_q;

  // Protocol invariants on grant and fetch interface
  a_sel_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(warp_selected_o));
  a_sel_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    (warp_selected_o & ~warp_ready_i) == '0);
  a_ready_active: assert property (@(posedge clk_i) disable iff (rst_i)
    (warp_ready_i & ~warp_active_i) == '0);
  a_fetch_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (fetch_valid_o && !fetch_ready_i) |=> (fetch_valid_o && $stable(fetch_wid_o)
      && $stable(fetch_pc_o) && $stable(fetch_act_mask_o)));

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Bench for warp_fetch_scheduler (4 warps): directed scenarios plus a randomized phase,
// all checked against a behavioural model of the scheduler and a stack that
// drops a warp's ready for two cycles after it is granted.
module tb_warp_fetch_scheduler;
  localparam int NW = 4;
  localparam int PW = 32;
  localparam int MW = 32;
  localparam int M_IDLE = 0, M_INIT = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              set_ready_o;
  logic [NW-1:0]     warp_active_i;
  logic [NW-1:0]     warp_stopped_i;
  logic [NW-1:0]     warp_ready_i;
  logic [NW*PW-1:0]  warp_pc_i;
  logic [NW*MW-1:0]  warp_act_mask_i;
  logic [NW-1:0]     warp_selected_o;
  logic              fetch_valid_o;
  logic              fetch_ready_i;
  logic [1:0]        fetch_wid_o;
  logic [PW-1:0]     fetch_pc_o;
  logic [MW-1:0]     fetch_act_mask_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       issued_cnt_o;

  warp_fetch_scheduler #(.PcWidth(PW), .NumWarps(NW), .WarpWidth(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .set_ready_o(set_ready_o),
    .warp_active_i(warp_active_i), .warp_stopped_i(warp_stopped_i),
    .warp_ready_i(warp_ready_i), .warp_pc_i(warp_pc_i), .warp_act_mask_i(warp_act_mask_i),
    .warp_selected_o(warp_selected_o), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_wid_o(fetch_wid_o), .fetch_pc_o(fetch_pc_o),
    .fetch_act_mask_o(fetch_act_mask_o), .busy_o(busy_o), .done_o(done_o),
    .issued_cnt_o(issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Stimulus state: ready enables and per-warp cooldown of the stack model
  logic [NW-1:0] en;
  int            cool [NW];
  logic [31:0]   pcs  [NW];
  logic [31:0]   masks[NW];
  logic [NW-1:0] obs_sel;

  // Reference model state
  int          m_st;
  bit          m_vld;
  int          m_wid;
  logic [31:0] m_pc, m_mask, m_cnt;
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_vld = 0; m_wid = 0; m_pc = '0; m_mask = '0; m_cnt = '0; m_ptr = 0;
    for (int w = 0; w < NW; w++) cool[w] = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_setrdy"}, set_ready_o, 0);
    chk({tag, "_sel"}, warp_selected_o, 0);
    chk({tag, "_valid"}, fetch_valid_o, 0);
    chk({tag, "_wid"}, fetch_wid_o, 0);
    chk({tag, "_pc"}, fetch_pc_o, 0);
    chk({tag, "_mask"}, fetch_act_mask_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_cnt"}, issued_cnt_o, 0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model across the edge
  task automatic step(input logic st, input logic frdy);
    logic [NW-1:0] rdy;
    int  g;
    bit  vld0, acc;
    start_i = st;
    fetch_ready_i = frdy;
    for (int w = 0; w < NW; w++) begin
      rdy[w] = en[w] && (cool[w] == 0);
      warp_pc_i[w*PW +: PW] = pcs[w];
      warp_act_mask_i[w*MW +: MW] = masks[w];
    end
    warp_ready_i = rdy;
    #2;
    obs_sel = warp_selected_o;
    chk("set_ready", set_ready_o, m_st == M_INIT);
    chk("busy", busy_o, (m_st == M_INIT) || (m_st == M_RUN) || (m_st == M_DRAIN));
    chk("done", done_o, m_st == M_DONE);
    chk("issued_cnt", issued_cnt_o, m_cnt);
    chk("fetch_valid", fetch_valid_o, m_vld);
    if (m_vld) begin
      chk("fetch_wid", fetch_wid_o, m_wid);
      chk("fetch_pc", fetch_pc_o, m_pc);
      chk("fetch_mask", fetch_act_mask_o, m_mask);
    end
    g = -1;
    if (m_st == M_RUN && (!m_vld || frdy)) begin
      for (int d = 0; d < NW; d++)
        if (g < 0 && rdy[(m_ptr + d) % NW]) g = (m_ptr + d) % NW;
    end
    chk("warp_selected", warp_selected_o, (g < 0) ? 64'd0 : (64'd1 << g));
    vld0 = m_vld;
    acc = m_vld && frdy;
    if (acc) m_cnt = m_cnt + 1;
    if (g >= 0) begin
      m_vld = 1; m_wid = g; m_pc = pcs[g]; m_mask = masks[g]; m_ptr = (g + 1) % NW;
    end else if (acc) begin
      m_vld = 0;
    end
    case (m_st)
      M_IDLE, M_DONE: if (st) begin m_st = M_INIT; m_cnt = '0; m_ptr = 0; end
      M_INIT:  m_st = M_RUN;
      M_RUN:   if (&warp_stopped_i) m_st = M_DRAIN;
      M_DRAIN: if (!vld0 || frdy) m_st = M_DONE;
      default: m_st = M_IDLE;
    endcase
    @(posedge clk_i);
    #1;
    for (int w = 0; w < NW; w++) if (cool[w] > 0) cool[w]--;
    if (g >= 0) cool[g] = 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0;
    logic [3:0]  exp_sel [4];
    rst_i = 1; start_i = 0; fetch_ready_i = 0;
    warp_active_i = '1; warp_stopped_i = '0; warp_ready_i = '0;
    warp_pc_i = '0; warp_act_mask_i = '0; en = '0;
    for (int w = 0; w < NW; w++) begin
      pcs[w] = 32'h1000 + 32'(w) * 32'h10;
      masks[w] = 32'hF0F0_0000 | 32'(w);
    end
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 0;

    // Kernel start: set_ready_o exactly one cycle after start
    step(1, 1);
    chk("init_set_ready", set_ready_o, 1);
    chk("init_busy", busy_o, 1);
    en = 4'b1111;
    step(0, 1);
    chk("run_set_ready_low", set_ready_o, 0);

    // All ready with fetch_ready=1: grants 0,1,2,3,0 (a start during RUN is ignored)
    step(1, 1);
    chk("rr_grant0", obs_sel, 4'b0001);
    exp_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      step(0, 1);
      chk("rr_grant_seq", obs_sel, exp_sel[k]);
    end
    chk("start_ignored_busy", busy_o, 1);

    // Only warps 1 and 3 ready; after 3 the search wraps to 1
    en = 4'b1010;
    step(0, 1); chk("w13_grant1", obs_sel, 4'b0010);
    step(0, 1); chk("w13_grant3", obs_sel, 4'b1000);
    step(0, 1); chk("w13_none", obs_sel, 4'b0000);
    step(0, 1); chk("w13_wrap_to_1", obs_sel, 4'b0010);
    chk("w13_fetch_wid", fetch_wid_o, 1);
    chk("w13_fetch_pc", fetch_pc_o, pcs[1]);
    chk("w13_fetch_mask", fetch_act_mask_o, masks[1]);

    // Backpressure: request wid=2 pc=0x40 held for 5 cycles
    en = 4'b0100;
    pcs[2] = 32'h40;
    step(0, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0);
      chk("hold_sel", obs_sel, 0);
      chk("hold_wid", fetch_wid_o, 2);
      chk("hold_pc", fetch_pc_o, 32'h40);
      chk("hold_valid", fetch_valid_o, 1);
    end
    c0 = issued_cnt_o;
    en = 4'b0000;
    step(0, 1);
    chk("release_cnt", issued_cnt_o, c0 + 32'd1);
    chk("release_valid", fetch_valid_o, 0);

    // Drain: all warps stop while a request is held
    en = 4'b0100;
    step(0, 1);
    warp_stopped_i = '1;
    step(0, 0);
    step(0, 0);
    chk("drain_busy", busy_o, 1);
    chk("drain_done", done_o, 0);
    chk("drain_sel", obs_sel, 0);
    step(0, 1);
    chk("done_flag", done_o, 1);
    chk("done_busy", busy_o, 0);
    warp_stopped_i = '0;
    step(1, 0);
    chk("restart_set_ready", set_ready_o, 1);
    chk("restart_cnt", issued_cnt_o, 0);
    step(0, 1);

    // Randomized run against the model
    for (int k = 0; k < 400; k++) begin
      en = 4'($urandom);
      for (int w = 0; w < NW; w++) begin
        pcs[w] = $urandom;
        masks[w] = $urandom;
      end
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    // Reset mid-RUN with a valid request
    en = 4'b1111;
    for (int k = 0; k < 10 && !m_vld; k++) step(0, 0);
    chk("pre_reset_valid", fetch_valid_o, 1);
    rst_i = 1;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 0;
    en = '0;
    step(0, 0);
    chk("post_reset_idle_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
